// File: rtl/mips_run_ctrl.sv
// Run controller and memory-port arbiter for the 8-bit multicycle MIPS core.
// The host owns memory while halted; RUN releases the core for a bounded or unbounded budget.
module mips_run_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CYCW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_cmd_valid,
    input  logic [1:0]       host_cmd,
    input  logic [WIDTH-1:0] host_adr,
    input  logic [WIDTH-1:0] host_wdata,
    input  logic [CYCW-1:0]  host_run_cycles,
    output logic             host_cmd_ready,
    output logic [WIDTH-1:0] host_rdata,
    output logic             host_rvalid,
    output logic             running,
    output logic             done,
    output logic             core_reset,
    input  logic [WIDTH-1:0] core_adr,
    input  logic [WIDTH-1:0] core_writedata,
    input  logic             core_memwrite,
    output logic [WIDTH-1:0] core_memdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] CmdRead  = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdRun   = 2'b10;
    localparam logic [1:0] CmdHalt  = 2'b11;

    typedef enum logic {StHalted, StRun} state_t;

    state_t           r_state;
    logic [CYCW-1:0]  r_cnt;
    logic             r_bounded;
    logic             r_done;
    logic             r_rvalid;
    logic [WIDTH-1:0] r_rdata;

    logic w_run;
    logic w_accept;
    logic w_expire;

    assign w_run    = (r_state == StRun);
    assign w_accept = host_cmd_valid & host_cmd_ready;
    assign w_expire = w_run & r_bounded & (r_cnt == CYCW'(1));

    // While running only HALT/RUN (cmd[1] set) may pass; host memory accesses stall.
    always_comb begin
        host_cmd_ready = 1'b0;
        if (!reset) begin
            host_cmd_ready = w_run ? host_cmd[1] : 1'b1;
        end
    end

    always_comb begin
        mem_adr   = host_adr;
        mem_wdata = host_wdata;
        mem_we    = 1'b0;
        if (w_run) begin
            mem_adr   = core_adr;
            mem_wdata = core_writedata;
            mem_we    = core_memwrite & ~reset;
        end else begin
            mem_we    = host_cmd_valid & (host_cmd == CmdWrite) & ~reset;
        end
    end

    assign core_memdata = mem_rdata;
    assign running      = w_run;
    assign core_reset   = reset | ~w_run;
    assign done         = r_done;
    assign host_rvalid  = r_rvalid;
    assign host_rdata   = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StHalted;
            r_cnt     <= '0;
            r_bounded <= 1'b0;
            r_done    <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            if (!w_run) begin
                if (w_accept && host_cmd == CmdRead) begin
                    r_rdata  <= mem_rdata;
                    r_rvalid <= 1'b1;
                end
                if (w_accept && host_cmd == CmdRun) begin
                    r_cnt     <= host_run_cycles;
                    r_bounded <= (host_run_cycles != '0);
                    r_state   <= StRun;
                end
            end else if (w_accept && host_cmd == CmdRun) begin
                // A reload wins over a simultaneous expiry; the core is not restarted.
                r_cnt     <= host_run_cycles;
                r_bounded <= (host_run_cycles != '0);
            end else if ((w_accept && host_cmd == CmdHalt) || w_expire) begin
                r_state <= StHalted;
                r_done  <= w_expire;
            end else if (r_bounded) begin
                r_cnt <= r_cnt - CYCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios plus a randomized run against a cycle model
// that tracks memory contents, remaining budget and pending pulses.
module tb_mips_run_ctrl;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_cmd_valid;
    logic [1:0]  host_cmd;
    logic [7:0]  host_adr, host_wdata, host_rdata;
    logic [15:0] host_run_cycles;
    logic        host_cmd_ready, host_rvalid, running, done, core_reset;
    logic [7:0]  core_adr, core_writedata, core_memdata;
    logic        core_memwrite;
    logic [7:0]  mem_adr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];
    logic        tb_clear;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(.WIDTH(8), .CYCW(16)) dut (
        .clk(clk), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd), .host_adr(host_adr),
        .host_wdata(host_wdata), .host_run_cycles(host_run_cycles),
        .host_cmd_ready(host_cmd_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .running(running), .done(done), .core_reset(core_reset),
        .core_adr(core_adr), .core_writedata(core_writedata), .core_memwrite(core_memwrite),
        .core_memdata(core_memdata), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Memory device attached to the arbitrated port.
    assign mem_rdata = mem[mem_adr];
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_adr] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] c, input logic [7:0] a,
                         input logic [7:0] d, input int n);
        host_cmd_valid  = v;
        host_cmd        = c;
        host_adr        = a;
        host_wdata      = d;
        host_run_cycles = 16'(n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(1'b1, CMD_WRITE, 8'h05, 8'hFF, 0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (host_cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", host_cmd_ready); end
        tick();
        tb_clear = 1'b0;
        @(negedge clk);
        checks++; if ({running, core_reset, done, host_rvalid} !== 4'b0100) begin
            failures++; $display("FAIL reset_outs run/creset/done/rvalid got=%b exp=0100",
                                 {running, core_reset, done, host_rvalid});
        end
        checks++; if (host_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", host_rdata); end
        tick();
        reset = 1'b0;
        issue(1'b0, CMD_HALT, 8'h00, 8'h00, 0);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        tick();
        issue(1'b1, CMD_READ, a, 8'h00, 0);
        @(negedge clk);
        checks++; if (host_cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", tag, host_cmd_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL %s_we got=%b exp=0", tag, mem_we); end
        tick();
        host_cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== exp_mem[a]) begin
            failures++; $display("FAIL %s_data rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                                 tag, host_rvalid, host_rdata, exp_mem[a]);
        end
        tick();
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b0) begin failures++; $display("FAIL %s_pulse got=%b exp=0", tag, host_rvalid); end
    endtask

    task automatic test_write_read();
        tick();
        issue(1'b1, CMD_WRITE, 8'h05, 8'h3C, 0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_adr !== 8'h05 || mem_wdata !== 8'h3C) begin
            failures++; $display("FAIL wr_port we=%b adr=%h wd=%h exp 1/05/3c", mem_we, mem_adr, mem_wdata);
        end
        exp_mem[8'h05] = 8'h3C;
        do_read(8'h05, "wr_read");
    endtask

    task automatic test_run_bounded(input int n, input bit plan);
        int cnt = 0;
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, n);
        @(negedge clk);
        checks++; if (host_cmd_ready !== 1'b1 || running !== 1'b0) begin
            failures++; $display("FAIL runb_accept ready=%b running=%b exp 1/0", host_cmd_ready, running);
        end
        tick();
        host_cmd_valid = 1'b0;
        while (running === 1'b1 && cnt < n + 8) begin
            core_adr       = plan ? 8'(cnt) : 8'($urandom);
            core_memwrite  = plan ? (cnt == 2) : ($urandom_range(0, 1) == 1);
            core_writedata = plan ? 8'h7E : 8'($urandom);
            @(negedge clk);
            checks++; if (mem_adr !== core_adr || mem_we !== core_memwrite || core_reset !== 1'b0 || done !== 1'b0) begin
                failures++; $display("FAIL runb_cycle adr=%h we=%b creset=%b done=%b exp %h/%b/0/0",
                                     mem_adr, mem_we, core_reset, done, core_adr, core_memwrite);
            end
            if (core_memwrite) exp_mem[core_adr] = core_writedata;
            cnt++;
            tick();
        end
        core_memwrite = 1'b0;
        @(negedge clk);
        checks++; if (cnt !== n) begin failures++; $display("FAIL runb_len got=%0d exp=%0d", cnt, n); end
        checks++; if (done !== 1'b1 || core_reset !== 1'b1) begin
            failures++; $display("FAIL runb_done done=%b creset=%b exp 1/1", done, core_reset);
        end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL runb_done_pulse got=%b exp=0", done); end
        if (plan) begin
            checks++; if (exp_mem[8'h02] !== 8'h7E) begin failures++; $display("FAIL runb_store model=%h exp=7e", exp_mem[8'h02]); end
            do_read(8'h02, "runb_read");
        end
    endtask

    task automatic test_run_unbounded();
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tick();
            issue(i == 9, CMD_HALT, 8'h00, 8'h00, 0);
            @(negedge clk);
            checks++; if (running !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL unb_cycle%0d running=%b done=%b exp 1/0", i, running, done);
            end
        end
        checks++; if (host_cmd_ready !== 1'b1) begin failures++; $display("FAIL unb_halt_ready got=%b exp=1", host_cmd_ready); end
        tick();
        host_cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (running !== 1'b0 || done !== 1'b0 || core_reset !== 1'b1) begin
            failures++; $display("FAIL unb_halted running=%b done=%b creset=%b exp 0/0/1", running, done, core_reset);
        end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL unb_no_done got=%b exp=0", done); end
    endtask

    task automatic test_read_stall();
        int st = 0;
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, 4);
        @(negedge clk);
        tick();
        issue(1'b1, CMD_READ, 8'h05, 8'h00, 0);
        while (running === 1'b1 && st < 12) begin
            @(negedge clk);
            checks++; if (host_cmd_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", host_cmd_ready); end
            st++;
            tick();
        end
        @(negedge clk);
        checks++; if (st !== 4) begin failures++; $display("FAIL stall_len got=%0d exp=4", st); end
        checks++; if (host_cmd_ready !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL stall_accept ready=%b done=%b exp 1/1", host_cmd_ready, done);
        end
        tick();
        host_cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== exp_mem[8'h05]) begin
            failures++; $display("FAIL stall_data rvalid=%b rdata=%h exp 1/%h", host_rvalid, host_rdata, exp_mem[8'h05]);
        end
    endtask

    task automatic test_halt_at_expiry();
        int n = $urandom_range(2, 6);
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            tick();
            issue(i == n - 1, CMD_HALT, 8'h00, 8'h00, 0);
            @(negedge clk);
            checks++; if (running !== 1'b1) begin failures++; $display("FAIL hexp_running%0d got=%b exp=1", i, running); end
        end
        tick();
        host_cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (running !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL hexp_end running=%b done=%b exp 0/1", running, done);
        end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL hexp_pulse got=%b exp=0", done); end
    endtask

    task automatic test_reload_at_expiry();
        int cnt = 0;
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, 3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            issue(i == 2, CMD_RUN, 8'h00, 8'h00, 5);
            @(negedge clk);
        end
        tick();
        host_cmd_valid = 1'b0;
        while (running === 1'b1 && cnt < 12) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL reload_done got=%b exp=0", done); end
            cnt++;
            tick();
        end
        @(negedge clk);
        checks++; if (cnt !== 5 || done !== 1'b1) begin
            failures++; $display("FAIL reload_len cycles=%0d done=%b exp 5/1", cnt, done);
        end
    endtask

    task automatic test_reset_mid_run();
        tick();
        issue(1'b1, CMD_RUN, 8'h00, 8'h00, 0);
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b1;
        issue(1'b1, CMD_WRITE, 8'h05, 8'hA5, 0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || host_cmd_ready !== 1'b0) begin
            failures++; $display("FAIL rstrun_pre we=%b ready=%b exp 0/0", mem_we, host_cmd_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            checks++; if ({running, core_reset, mem_we, done, host_rvalid} !== 5'b01000 || host_rdata !== 8'h00) begin
                failures++; $display("FAIL rstrun_post run/creset/we/done/rvalid=%b rdata=%h exp 01000/00",
                                     {running, core_reset, mem_we, done, host_rvalid}, host_rdata);
            end
        end
        tick();
        reset = 1'b0;
        host_cmd_valid = 1'b0;
        @(negedge clk);
        do_read(8'h05, "rstrun_read");
    endtask

    task automatic test_random();
        bit m_run = 0, m_done = 0, m_rv = 0, acc, expire, e_ready, e_we;
        int m_left = 0;
        logic [7:0] m_rdata = 8'h00, e_adr, e_wd;
        int r;
        for (int c = 0; c < 400; c++) begin
            tick();
            r = $urandom_range(0, 15);
            issue($urandom_range(0, 3) != 0,
                  (r < 6) ? CMD_READ : (r < 12) ? CMD_WRITE : (r < 14) ? CMD_HALT : CMD_RUN,
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 6));
            core_adr       = 8'($urandom);
            core_writedata = 8'($urandom);
            core_memwrite  = ($urandom_range(0, 2) == 0);
            e_ready = m_run ? host_cmd[1] : 1'b1;
            e_adr   = m_run ? core_adr : host_adr;
            e_wd    = m_run ? core_writedata : host_wdata;
            e_we    = m_run ? core_memwrite : (host_cmd_valid && host_cmd == CMD_WRITE);
            @(negedge clk);
            checks++; if (running !== m_run || core_reset !== !m_run || host_cmd_ready !== e_ready) begin
                failures++; $display("FAIL rnd_ctl c=%0d run=%b creset=%b ready=%b exp %b/%b/%b",
                                     c, running, core_reset, host_cmd_ready, m_run, !m_run, e_ready);
            end
            checks++; if (mem_adr !== e_adr || mem_we !== e_we || mem_wdata !== e_wd || core_memdata !== exp_mem[e_adr]) begin
                failures++; $display("FAIL rnd_port c=%0d adr=%h we=%b wd=%h cdata=%h exp %h/%b/%h/%h",
                                     c, mem_adr, mem_we, mem_wdata, core_memdata, e_adr, e_we, e_wd, exp_mem[e_adr]);
            end
            checks++; if (done !== m_done || host_rvalid !== m_rv || (m_rv && host_rdata !== m_rdata)) begin
                failures++; $display("FAIL rnd_pulse c=%0d done=%b rvalid=%b rdata=%h exp %b/%b/%h",
                                     c, done, host_rvalid, host_rdata, m_done, m_rv, m_rdata);
            end
            acc    = host_cmd_valid && e_ready;
            m_done = 0;
            m_rv   = 0;
            if (!m_run) begin
                if (acc && host_cmd == CMD_READ) begin m_rv = 1; m_rdata = exp_mem[host_adr]; end
                if (acc && host_cmd == CMD_RUN) begin m_run = 1; m_left = int'(host_run_cycles); end
            end else if (acc && host_cmd == CMD_RUN) begin
                m_left = int'(host_run_cycles);
            end else begin
                // m_left == 0 means the budget is unbounded.
                expire = (m_left == 1);
                if ((acc && host_cmd == CMD_HALT) || expire) begin
                    m_run  = 0;
                    m_done = expire;
                end else if (m_left > 1) begin
                    m_left--;
                end
            end
            if (e_we) exp_mem[e_adr] = e_wd;
        end
        tick();
        host_cmd_valid = 1'b0;
        core_memwrite  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tb_clear = 1'b1;
        core_adr = 8'h00;
        core_writedata = 8'h00;
        core_memwrite = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_run_bounded(3, 1'b1);
        test_run_bounded($urandom_range(1, 20), 1'b0);
        test_run_unbounded();
        test_read_stall();
        test_halt_at_expiry();
        test_reload_at_expiry();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
